// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: opcodes, fetch FSM encoding, reset PC
// and the branch-offset helper used by the fetch stage.
package mips_lite_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_NORI  = 6'd13;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    ERROR = 2'd3
  } fetch_state_t;

  // Sign-extended word offset of a beq immediate, as a byte displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and instruction memory (slave).
interface ifetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_watchdog.sv
// Wait-state watchdog for the fetch stage: counts consecutive cycles
// without an acknowledge and flags when the last allowed cycle is reached.
module fetch_watchdog #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count_reg;

  // Wait-cycle counter; clear wins over enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Expire marks the final FETCH cycle in which an ack is still accepted.
  assign expire = (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ifetch_unit.sv
// MIPS-lite instruction-fetch stage: owns the PC, fetches over a
// req/ack bus with wait states, holds the IR and selects the next PC.
module ifetch_unit
  import mips_lite_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  ifetch_unit_if.master        imem,
  input  logic                 exec_done,
  input  logic                 branch,
  input  logic                 zero,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic                 instr_valid,
  output logic                 fetch_err
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  branch_target;
  logic         wd_clear, wd_enable, wd_expire;

  fetch_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = pc_plus4 + branch_offset(instr_reg[15:0]);

  // State, PC and instruction register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
    end
  end

  // Next-state, PC select and IR load; acks are only honoured in FETCH.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    wd_clear   = 1'b1;
    wd_enable  = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        wd_clear = 1'b0;
        if (imem.imem_ack) begin
          instr_next = imem.imem_rdata;
          wd_clear   = 1'b1;
          state_next = EXEC;
        end else if (wd_expire) begin
          state_next = ERROR;
        end else begin
          wd_enable = 1'b1;
        end
      end
      EXEC: begin
        if (exec_done) begin
          pc_next    = (branch && zero) ? branch_target : pc_plus4;
          state_next = FETCH;
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus and status outputs depend on registered state only.
  assign imem.imem_req  = (state_reg == FETCH);
  assign imem.imem_addr = pc_reg;
  assign instr_valid    = (state_reg == EXEC);
  assign fetch_err      = (state_reg == ERROR);
  assign pc             = pc_reg;
  assign instr          = instr_reg;
  assign opcode         = instr_reg[31:26];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed self-checking bench for ifetch_unit with a fetch scoreboard.
module tb_ifetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        exec_done, branch, zero;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0]  opcode;
  logic        instr_valid, fetch_err;

  logic        exec_done1, branch1, zero1;
  logic [31:0] pc1, pc_plus4_1, instr1;
  logic [5:0]  opcode1;
  logic        instr_valid1, fetch_err1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;
  fetch_t      exp_q[$];

  ifetch_unit_if bus0 ();
  ifetch_unit_if bus1 ();

  ifetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus0),
    .exec_done   (exec_done),
    .branch      (branch),
    .zero        (zero),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .reset       (reset),
    .imem        (bus1),
    .exec_done   (exec_done1),
    .branch      (branch1),
    .zero        (zero1),
    .pc          (pc1),
    .pc_plus4    (pc_plus4_1),
    .instr       (instr1),
    .opcode      (opcode1),
    .instr_valid (instr_valid1),
    .fetch_err   (fetch_err1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One instruction: optional wait states, zero or more idle EXEC cycles
  // with a stray ack, then exec_done with the given branch/zero.
  task automatic run_instr(input logic [31:0] word, input int waits, input int hold,
                           input logic br, input logic zr);
    fetch_t      e;
    logic [31:0] prev_instr;
    logic [31:0] nxt;
    prev_instr = instr;
    for (int i = 0; i < waits; i++) begin
      chk1("wait_req", bus0.imem_req, 1'b1);
      chk("wait_addr", bus0.imem_addr, model_pc);
      chk("wait_instr", instr, prev_instr);
      tick();
    end
    chk1("fetch_req", bus0.imem_req, 1'b1);
    chk("fetch_addr", bus0.imem_addr, model_pc);
    bus0.imem_ack   = 1'b1;
    bus0.imem_rdata = word;
    exp_q.push_back(fetch_t'{pc: model_pc, instr: word});
    tick();
    bus0.imem_ack   = 1'b0;
    bus0.imem_rdata = '0;
    chk1("exec_valid", instr_valid, 1'b1);
    chk1("exec_req", bus0.imem_req, 1'b0);
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL sb_empty: observed 0 entries expected 1");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("exec_pc", pc, e.pc);
      chk("exec_instr", instr, e.instr);
      chk("exec_opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
      chk("exec_pc_plus4", pc_plus4, e.pc + 32'd4);
    end
    for (int i = 0; i < hold; i++) begin
      bus0.imem_ack   = 1'b1;
      bus0.imem_rdata = 32'hDEAD_BEEF;
      branch          = 1'b1;
      zero            = 1'b1;
      tick();
      chk1("hold_valid", instr_valid, 1'b1);
      chk("hold_instr", instr, word);
      chk("hold_pc", pc, model_pc);
    end
    bus0.imem_ack   = 1'b0;
    bus0.imem_rdata = '0;
    exec_done = 1'b1;
    branch    = br;
    zero      = zr;
    tick();
    exec_done = 1'b0;
    branch    = 1'b0;
    zero      = 1'b0;
    nxt = model_pc + 32'd4;
    if (br && zr) nxt = nxt + {{14{word[15]}}, word[15:0], 2'b00};
    model_pc = nxt;
    chk("next_addr", bus0.imem_addr, model_pc);
    chk1("next_req", bus0.imem_req, 1'b1);
    chk1("next_valid", instr_valid, 1'b0);
    chk1("next_err", fetch_err, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    exec_done = 1'b0; branch = 1'b0; zero = 1'b0;
    bus0.imem_ack = 1'b0; bus0.imem_rdata = '0;
    exec_done1 = 1'b0; branch1 = 1'b0; zero1 = 1'b0;
    bus1.imem_ack = 1'b0; bus1.imem_rdata = '0;
    model_pc = 32'h0;
    tick();
    tick();

    // Reset state
    chk1("rst_req", bus0.imem_req, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_err", fetch_err, 1'b0);
    chk("rst_pc_wrap_dut", pc1, 32'hFFFF_FFFC);

    reset = 1'b0;
    chk1("idle_req", bus0.imem_req, 1'b0);
    tick();

    // Zero-wait lw at pc 0
    run_instr(32'h8C22_0004, 0, 0, 1'b0, 1'b0);
    chk("lw_next_pc", bus0.imem_addr, 32'h4);
    // Three wait states, then stray acks during EXEC
    run_instr(32'h0000_0020, 3, 2, 1'b0, 1'b0);
    run_instr(32'h3400_0001, 0, 0, 1'b0, 1'b0);
    run_instr(32'hAC22_0008, 1, 0, 1'b0, 1'b0);
    // beq at 0x10 taken back to 0x4
    chk("beq_pc", bus0.imem_addr, 32'h10);
    run_instr(32'h1000_FFFC, 0, 0, 1'b1, 1'b1);
    chk("beq_taken", bus0.imem_addr, 32'h4);
    run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b1);
    run_instr(32'h0000_0020, 0, 0, 1'b1, 1'b0);
    run_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0);
    // Same beq, zero=0 falls through to 0x14
    chk("beq2_pc", bus0.imem_addr, 32'h10);
    run_instr(32'h1000_FFFC, 0, 0, 1'b1, 1'b0);
    chk("beq_not_taken", bus0.imem_addr, 32'h14);

    // No ack: 16 FETCH cycles, then ERROR
    for (int i = 0; i < 16; i++) begin
      chk1("to_req", bus0.imem_req, 1'b1);
      chk1("to_err_low", fetch_err, 1'b0);
      tick();
    end
    chk1("err_flag", fetch_err, 1'b1);
    chk1("err_req", bus0.imem_req, 1'b0);
    chk1("err_valid", instr_valid, 1'b0);
    chk("err_pc", pc, 32'h14);
    for (int i = 0; i < 3; i++) begin
      bus0.imem_ack   = 1'b1;
      bus0.imem_rdata = 32'h1234_5678;
      tick();
      chk1("err_sticky", fetch_err, 1'b1);
      chk("err_pc_frozen", pc, 32'h14);
      chk("err_instr_kept", instr, 32'h1000_FFFC);
    end
    bus0.imem_ack   = 1'b0;
    bus0.imem_rdata = '0;
    reset = 1'b1;
    #1;
    chk1("err_rst_flag", fetch_err, 1'b0);
    chk("err_rst_pc", pc, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Reset while in EXEC
    chk1("mid_req", bus0.imem_req, 1'b1);
    bus0.imem_ack   = 1'b1;
    bus0.imem_rdata = 32'h8C22_0004;
    tick();
    bus0.imem_ack   = 1'b0;
    chk1("mid_valid", instr_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk1("mid_rst_valid", instr_valid, 1'b0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk1("mid_rst_req", bus0.imem_req, 1'b0);
    tick();
    bus0.imem_ack   = 1'b1;
    bus0.imem_rdata = 32'hAAAA_5555;
    reset = 1'b0;
    tick();
    bus0.imem_ack   = 1'b0;
    bus0.imem_rdata = '0;
    chk1("idle_ack_req", bus0.imem_req, 1'b1);
    chk1("idle_ack_valid", instr_valid, 1'b0);
    chk("idle_ack_instr", instr, 32'h0);
    tick();
    chk1("idle_ack_req2", bus0.imem_req, 1'b1);
    chk1("idle_ack_valid2", instr_valid, 1'b0);

    // PC wrap from 0xFFFF_FFFC
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk1("wrap_req", bus1.imem_req, 1'b1);
    chk("wrap_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    bus1.imem_ack   = 1'b1;
    bus1.imem_rdata = 32'h0000_0020;
    tick();
    bus1.imem_ack   = 1'b0;
    chk1("wrap_valid", instr_valid1, 1'b1);
    chk("wrap_plus4", pc_plus4_1, 32'h0);
    exec_done1 = 1'b1;
    tick();
    exec_done1 = 1'b0;
    chk("wrap_next_addr", bus1.imem_addr, 32'h0);
    chk1("wrap_no_err", fetch_err1, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
